// File: rtl/ahb_rr_arbiter_if.sv
// Bus-side signal bundle for the round-robin AHB arbiter.
// The master modport is the requesting side (masters plus the slave's HREADY);
// the slave modport is the arbiter itself.
interface ahb_rr_arbiter_if #(
  parameter int MASTER_NUM = 4
);
  localparam int MW = $clog2(MASTER_NUM);

  logic [MASTER_NUM-1:0]   m_busreq;
  logic [MASTER_NUM-1:0]   m_hlock;
  logic [2*MASTER_NUM-1:0] m_htrans;
  logic [3*MASTER_NUM-1:0] m_hburst;
  logic                    hready;
  logic [MASTER_NUM-1:0]   hgrant;
  logic [MW-1:0]           hmaster;
  logic                    hmaster_lock;
  logic [4:0]              beats_left;

  modport master (
    output m_busreq, m_hlock, m_htrans, m_hburst, hready,
    input  hgrant, hmaster, hmaster_lock, beats_left
  );

  modport slave (
    input  m_busreq, m_hlock, m_htrans, m_hburst, hready,
    output hgrant, hmaster, hmaster_lock, beats_left
  );
endinterface

// File: rtl/ahb_rr_arbiter.sv
// Round-robin AHB arbiter: hands the bus over only at burst boundaries,
// INCR tenure expiry or IDLE, honours HLOCK, and parks on a default master.
module ahb_rr_arbiter #(
  parameter int MASTER_NUM     = 4,
  parameter int DEFAULT_MASTER = MASTER_NUM - 1,
  parameter int MAX_TENURE     = 16
) (
  input logic             hclk,
  input logic             hreset,
  ahb_rr_arbiter_if.slave bus
);
  localparam int MW = $clog2(MASTER_NUM);
  localparam logic [MASTER_NUM-1:0] ONE     = {{(MASTER_NUM-1){1'b0}}, 1'b1};
  localparam logic [MW-1:0]         DEF_IDX = MW'(DEFAULT_MASTER);

  localparam logic [1:0] HT_IDLE   = 2'b00;
  localparam logic [1:0] HT_NONSEQ = 2'b10;
  localparam logic [1:0] HT_SEQ    = 2'b11;
  localparam logic [2:0] HB_INCR   = 3'b001;

  typedef enum logic [1:0] {
    ST_PARK   = 2'd0,
    ST_BURST  = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  logic [MASTER_NUM-1:0] r_hgrant;
  logic [MW-1:0]         r_hmaster;
  logic [MW-1:0]         r_last_winner;
  logic                  r_hmaster_lock;
  logic [4:0]            r_beats_left;
  logic [4:0]            r_tenure;
  state_t                r_state;

  logic [1:0]    w_htrans [MASTER_NUM];
  logic [2:0]    w_hburst [MASTER_NUM];
  logic [1:0]    w_ot;
  logic [2:0]    w_ob;
  logic [MW-1:0] w_gidx;
  logic [4:0]    w_len;
  logic          w_beat;
  logic          w_locked;
  logic          w_handover;
  logic          w_any_req;
  logic [MW-1:0] w_win_hi;
  logic [MW-1:0] w_win_lo;
  logic          w_hi_found;
  logic          w_lo_found;
  logic [MW-1:0] w_win;

  // Unpack the per-master transfer type and burst fields.
  for (genvar gi = 0; gi < MASTER_NUM; gi++) begin : g_split
    assign w_htrans[gi] = bus.m_htrans[2*gi +: 2];
    assign w_hburst[gi] = bus.m_hburst[3*gi +: 3];
  end

  // The address-phase owner's transfer decides burst tracking and handover.
  assign w_ot = w_htrans[r_hmaster];
  assign w_ob = w_hburst[r_hmaster];

  // Encode the one-hot grant back to an index.
  always_comb begin
    w_gidx = '0;
    for (int i = 0; i < MASTER_NUM; i++) begin
      if (r_hgrant[i]) w_gidx = MW'(i);
    end
  end

  // Burst length of the owner's current burst; undefined INCR gets the tenure cap.
  always_comb begin
    case (w_ob)
      3'b000:         w_len = 5'd1;
      3'b001:         w_len = 5'(MAX_TENURE);
      3'b010, 3'b011: w_len = 5'd4;
      3'b100, 3'b101: w_len = 5'd8;
      default:        w_len = 5'd16;
    endcase
  end

  assign w_beat   = (w_ot == HT_NONSEQ) || (w_ot == HT_SEQ);
  assign w_locked = bus.m_busreq[w_gidx] & bus.m_hlock[w_gidx];
  assign w_any_req = |bus.m_busreq;

  assign w_handover = !w_locked &&
                      ((w_ot == HT_IDLE) ||
                       ((w_ot == HT_NONSEQ) && (w_len == 5'd1)) ||
                       ((w_ot == HT_SEQ) && (r_beats_left == 5'd1)) ||
                       ((w_ob == HB_INCR) && w_beat && (r_tenure == 5'(MAX_TENURE - 1))) ||
                       (r_state == ST_PARK));

  // Round-robin pick: lowest requester above last_winner, else lowest at or below it.
  always_comb begin
    w_win_hi   = '0;
    w_win_lo   = '0;
    w_hi_found = 1'b0;
    w_lo_found = 1'b0;
    for (int i = MASTER_NUM - 1; i >= 0; i--) begin
      if (bus.m_busreq[i]) begin
        if (MW'(i) > r_last_winner) begin
          w_win_hi   = MW'(i);
          w_hi_found = 1'b1;
        end else begin
          w_win_lo   = MW'(i);
          w_lo_found = 1'b1;
        end
      end
    end
    if (w_hi_found)      w_win = w_win_hi;
    else if (w_lo_found) w_win = w_win_lo;
    else                 w_win = DEF_IDX;
  end

  // Arbitration state, burst tracking and FSM; everything stalls while hready is low.
  always_ff @(posedge hclk) begin
    if (hreset) begin
      r_hgrant       <= ONE << DEF_IDX;
      r_hmaster      <= DEF_IDX;
      r_hmaster_lock <= 1'b0;
      r_beats_left   <= 5'd0;
      r_tenure       <= 5'd0;
      r_last_winner  <= DEF_IDX;
      r_state        <= ST_PARK;
    end else if (bus.hready) begin
      r_hmaster      <= w_gidx;
      r_hmaster_lock <= bus.m_hlock[w_gidx];

      if (w_ot == HT_NONSEQ) begin
        r_beats_left <= w_len - 5'd1;
      end else if (w_ot == HT_SEQ) begin
        r_beats_left <= (r_beats_left == 5'd0) ? 5'd0 : r_beats_left - 5'd1;
      end

      // Tenure restarts whenever address-phase ownership moves to another master.
      if (w_gidx != r_hmaster) begin
        r_tenure <= 5'd0;
      end else if (w_beat && (r_tenure != 5'd31)) begin
        r_tenure <= r_tenure + 5'd1;
      end

      if (w_handover) begin
        r_hgrant <= ONE << w_win;
        if (w_any_req) r_last_winner <= w_win;
      end

      case (r_state)
        ST_PARK: begin
          if (w_any_req) r_state <= ST_BURST;
        end
        ST_BURST: begin
          if (w_locked)                     r_state <= ST_LOCKED;
          else if (w_handover && !w_any_req) r_state <= ST_PARK;
        end
        ST_LOCKED: begin
          if (!w_locked) r_state <= ST_BURST;
        end
        default: r_state <= ST_PARK;
      endcase
    end
  end

  assign bus.hgrant       = r_hgrant;
  assign bus.hmaster      = r_hmaster;
  assign bus.hmaster_lock = r_hmaster_lock;
  assign bus.beats_left   = r_beats_left;
endmodule

// File: tb/tb_ahb_rr_arbiter.sv
// Scenario bench for ahb_rr_arbiter (4 masters, default master 3, tenure 16).
// Each edge's expected outputs are queued as the stimulus is driven and
// popped for comparison once the edge has been taken.
module tb_ahb_rr_arbiter;
  localparam int MN = 4;

  localparam logic [1:0] IDLE   = 2'b00;
  localparam logic [1:0] NONSEQ = 2'b10;
  localparam logic [1:0] SEQ    = 2'b11;
  localparam logic [2:0] SINGLE = 3'b000;
  localparam logic [2:0] INCR   = 3'b001;
  localparam logic [2:0] INCR4  = 3'b011;
  localparam logic [2:0] INCR8  = 3'b101;

  typedef struct packed {
    logic [3:0] grant;
    logic [1:0] master;
    logic       lock;
    logic [4:0] bl;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  exp_t sb_q[$];
  int   tests_run    = 0;
  int   tests_failed = 0;

  ahb_rr_arbiter_if #(.MASTER_NUM(MN)) bus ();

  ahb_rr_arbiter #(
    .MASTER_NUM(MN),
    .DEFAULT_MASTER(3),
    .MAX_TENURE(16)
  ) dut (
    .hclk  (clk),
    .hreset(rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input logic [3:0] g, input logic [1:0] m,
                              input logic l, input logic [4:0] b);
    return {g, m, l, b};
  endfunction

  task automatic set_m(input int m, input logic [1:0] tr, input logic [2:0] hb);
    bus.m_htrans[2*m +: 2] = tr;
    bus.m_hburst[3*m +: 3] = hb;
  endtask

  task automatic idle_all();
    bus.m_busreq = '0;
    bus.m_hlock  = '0;
    bus.m_htrans = '0;
    bus.m_hburst = '0;
  endtask

  task automatic push_tick(input exp_t e);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_all();
    bus.hready = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb_q.delete();
  endtask

  task automatic test_reset();
    exp_t e, act;
    rst = 1'b1;
    bus.hready   = 1'b1;
    bus.m_busreq = 4'b1111;
    for (int n = 1; n <= 4; n++) begin
      if (n == 2) begin
        rst = 1'b0;
        idle_all();
      end
      push_tick(mk(4'b1000, 2'd3, 1'b0, 5'd0));
      e   = sb_q.pop_front();
      act = {bus.hgrant, bus.hmaster, bus.hmaster_lock, bus.beats_left};
      tests_run++;
      if (act !== e) begin
        tests_failed++;
        $display("FAIL reset edge%0d: got grant=%b hmaster=%0d lock=%b bl=%0d, expected grant=%b hmaster=%0d lock=%b bl=%0d",
                 n, act.grant, act.master, act.lock, act.bl, e.grant, e.master, e.lock, e.bl);
      end
    end
  endtask

  task automatic test_round_robin();
    exp_t e, act;
    logic [3:0] eg [5];
    logic [1:0] em [5];
    eg = '{4'b0001, 4'b0010, 4'b0100, 4'b0001, 4'b0010};
    em = '{2'd3, 2'd0, 2'd1, 2'd2, 2'd0};
    do_reset();
    bus.m_busreq = 4'b0111;
    for (int m = 0; m < 3; m++) set_m(m, NONSEQ, SINGLE);
    for (int n = 0; n < 5; n++) begin
      push_tick(mk(eg[n], em[n], 1'b0, 5'd0));
      e   = sb_q.pop_front();
      act = {bus.hgrant, bus.hmaster, bus.hmaster_lock, bus.beats_left};
      tests_run++;
      if (act !== e) begin
        tests_failed++;
        $display("FAIL round_robin edge%0d: got grant=%b hmaster=%0d lock=%b bl=%0d, expected grant=%b hmaster=%0d lock=%b bl=%0d",
                 n + 1, act.grant, act.master, act.lock, act.bl, e.grant, e.master, e.lock, e.bl);
      end
    end
  endtask

  task automatic test_incr4_hold();
    exp_t e, act;
    do_reset();
    for (int n = 1; n <= 7; n++) begin
      case (n)
        1, 2: begin bus.m_busreq = 4'b0010; e = mk(4'b0010, (n == 1) ? 2'd3 : 2'd1, 1'b0, 5'd0); end
        3: begin bus.m_busreq = 4'b0110; set_m(1, NONSEQ, INCR4); e = mk(4'b0010, 2'd1, 1'b0, 5'd3); end
        4: begin set_m(1, SEQ, INCR4); e = mk(4'b0010, 2'd1, 1'b0, 5'd2); end
        5: begin set_m(1, SEQ, INCR4); e = mk(4'b0010, 2'd1, 1'b0, 5'd1); end
        6: begin bus.m_busreq = 4'b0100; set_m(1, SEQ, INCR4); e = mk(4'b0100, 2'd1, 1'b0, 5'd0); end
        default: begin set_m(1, IDLE, SINGLE); e = mk(4'b0100, 2'd2, 1'b0, 5'd0); end
      endcase
      push_tick(e);
      e   = sb_q.pop_front();
      act = {bus.hgrant, bus.hmaster, bus.hmaster_lock, bus.beats_left};
      tests_run++;
      if (act !== e) begin
        tests_failed++;
        $display("FAIL incr4_hold edge%0d: got grant=%b hmaster=%0d lock=%b bl=%0d, expected grant=%b hmaster=%0d lock=%b bl=%0d",
                 n, act.grant, act.master, act.lock, act.bl, e.grant, e.master, e.lock, e.bl);
      end
    end
  endtask

  task automatic test_wait_states();
    exp_t e, act;
    do_reset();
    for (int n = 1; n <= 10; n++) begin
      bus.hready = 1'b1;
      case (n)
        1, 2: begin bus.m_busreq = 4'b0010; e = mk(4'b0010, (n == 1) ? 2'd3 : 2'd1, 1'b0, 5'd0); end
        3: begin bus.m_busreq = 4'b0110; set_m(1, NONSEQ, INCR4); e = mk(4'b0010, 2'd1, 1'b0, 5'd3); end
        4: begin set_m(1, SEQ, INCR4); e = mk(4'b0010, 2'd1, 1'b0, 5'd2); end
        5: begin set_m(1, SEQ, INCR4); e = mk(4'b0010, 2'd1, 1'b0, 5'd1); end
        6, 7, 8: begin
          bus.hready = 1'b0;
          bus.m_busreq = 4'b0100;
          set_m(1, SEQ, INCR4);
          e = mk(4'b0010, 2'd1, 1'b0, 5'd1);
        end
        9: begin set_m(1, SEQ, INCR4); e = mk(4'b0100, 2'd1, 1'b0, 5'd0); end
        default: begin set_m(1, IDLE, SINGLE); e = mk(4'b0100, 2'd2, 1'b0, 5'd0); end
      endcase
      push_tick(e);
      e   = sb_q.pop_front();
      act = {bus.hgrant, bus.hmaster, bus.hmaster_lock, bus.beats_left};
      tests_run++;
      if (act !== e) begin
        tests_failed++;
        $display("FAIL wait_states edge%0d: got grant=%b hmaster=%0d lock=%b bl=%0d, expected grant=%b hmaster=%0d lock=%b bl=%0d",
                 n, act.grant, act.master, act.lock, act.bl, e.grant, e.master, e.lock, e.bl);
      end
    end
    bus.hready = 1'b1;
  endtask

  task automatic test_lock();
    exp_t e, act;
    logic [4:0] bl;
    do_reset();
    for (int n = 1; n <= 21; n++) begin
      if (n <= 19) begin
        bus.m_busreq = 4'b1001;
        bus.m_hlock  = 4'b0001;
      end else begin
        bus.m_busreq = 4'b1000;
        bus.m_hlock  = 4'b0000;
      end
      if (n == 3 || n == 12)                             set_m(0, NONSEQ, INCR8);
      else if ((n >= 4 && n <= 10) || (n >= 13 && n <= 19)) set_m(0, SEQ, INCR8);
      else                                               set_m(0, IDLE, INCR8);
      if (n == 3 || n == 12)      bl = 5'd7;
      else if (n >= 4 && n <= 10) bl = 5'(10 - n);
      else if (n >= 13 && n <= 19) bl = 5'(19 - n);
      else                        bl = 5'd0;
      if (n == 1)       e = mk(4'b0001, 2'd3, 1'b0, bl);
      else if (n <= 19) e = mk(4'b0001, 2'd0, 1'b1, bl);
      else if (n == 20) e = mk(4'b1000, 2'd0, 1'b0, bl);
      else              e = mk(4'b1000, 2'd3, 1'b0, bl);
      push_tick(e);
      e   = sb_q.pop_front();
      act = {bus.hgrant, bus.hmaster, bus.hmaster_lock, bus.beats_left};
      tests_run++;
      if (act !== e) begin
        tests_failed++;
        $display("FAIL lock edge%0d: got grant=%b hmaster=%0d lock=%b bl=%0d, expected grant=%b hmaster=%0d lock=%b bl=%0d",
                 n, act.grant, act.master, act.lock, act.bl, e.grant, e.master, e.lock, e.bl);
      end
    end
  endtask

  task automatic test_incr_tenure();
    exp_t e, act;
    do_reset();
    for (int n = 1; n <= 20; n++) begin
      if (n <= 2) begin
        bus.m_busreq = 4'b0100;
        e = mk(4'b0100, (n == 1) ? 2'd3 : 2'd2, 1'b0, 5'd0);
      end else if (n <= 18) begin
        bus.m_busreq = 4'b0101;
        set_m(2, (n == 3) ? NONSEQ : SEQ, INCR);
        e = mk((n == 18) ? 4'b0001 : 4'b0100, 2'd2, 1'b0, 5'(18 - n));
      end else if (n == 19) begin
        set_m(2, SEQ, INCR);
        e = mk(4'b0001, 2'd0, 1'b0, 5'd0);
      end else begin
        bus.m_busreq = 4'b0100;
        set_m(2, IDLE, INCR);
        set_m(0, NONSEQ, SINGLE);
        e = mk(4'b0100, 2'd0, 1'b0, 5'd0);
      end
      push_tick(e);
      e   = sb_q.pop_front();
      act = {bus.hgrant, bus.hmaster, bus.hmaster_lock, bus.beats_left};
      tests_run++;
      if (act !== e) begin
        tests_failed++;
        $display("FAIL incr_tenure edge%0d: got grant=%b hmaster=%0d lock=%b bl=%0d, expected grant=%b hmaster=%0d lock=%b bl=%0d",
                 n, act.grant, act.master, act.lock, act.bl, e.grant, e.master, e.lock, e.bl);
      end
    end
  endtask

  task automatic test_reset_midburst();
    exp_t e, act;
    do_reset();
    for (int n = 1; n <= 7; n++) begin
      case (n)
        1, 2: begin bus.m_busreq = 4'b0010; e = mk(4'b0010, (n == 1) ? 2'd3 : 2'd1, 1'b0, 5'd0); end
        3: begin set_m(1, NONSEQ, INCR4); e = mk(4'b0010, 2'd1, 1'b0, 5'd3); end
        4: begin set_m(1, SEQ, INCR4); e = mk(4'b0010, 2'd1, 1'b0, 5'd2); end
        5: begin rst = 1'b1; bus.hready = 1'b0; e = mk(4'b1000, 2'd3, 1'b0, 5'd0); end
        6: begin rst = 1'b0; bus.hready = 1'b1; idle_all(); e = mk(4'b1000, 2'd3, 1'b0, 5'd0); end
        default: begin bus.m_busreq = 4'b0110; e = mk(4'b0010, 2'd3, 1'b0, 5'd0); end
      endcase
      push_tick(e);
      e   = sb_q.pop_front();
      act = {bus.hgrant, bus.hmaster, bus.hmaster_lock, bus.beats_left};
      tests_run++;
      if (act !== e) begin
        tests_failed++;
        $display("FAIL reset_midburst edge%0d: got grant=%b hmaster=%0d lock=%b bl=%0d, expected grant=%b hmaster=%0d lock=%b bl=%0d",
                 n, act.grant, act.master, act.lock, act.bl, e.grant, e.master, e.lock, e.bl);
      end
    end
  endtask

  initial begin
    idle_all();
    bus.hready = 1'b1;
    test_reset();
    test_round_robin();
    test_incr4_hold();
    test_wait_states();
    test_lock();
    test_incr_tenure();
    test_reset_midburst();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion before 200000");
    $fatal(1, "watchdog expired");
  end
endmodule
